mux_pipe_sel: RTL and testbench
===============================

Name: mux_pipe_sel

Overview:
- Parametrised N-input, WIDTH-bit select followed by a STAGES-deep pipeline register chain. Each stage carries a valid bit.
- Used wherever a pipeline-stage operand or next-PC select must be registered with stall/flush control. Examples: ID/EX operand forwarding select, next-PC source select.
- Generalises the plain 2:1 combinational select to N inputs, adds configurable latency, stall/flush handling and out-of-range select detection.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 4, number of data inputs (2..16).
- SEL_W, 2, select width. Legal iff 2^SEL_W >= N.
- STAGES, 1, register stages between select and output (1..4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  packed inputs. Input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
- sel  input  SEL_W  binary index of the input to pass.
- in_valid  input  1  qualifies in_data/sel this cycle.
- stall  input  1  freeze all stages.
- flush  input  1  invalidate and zero all stages.
- out_data  output  WIDTH  data from the last stage.
- out_valid  output  1  valid bit of the last stage.
- sel_err  output  1  valid bit of the last stage AND the select for that item was out of range.

Behaviour:
- Reset: clk and a single asynchronous active-low reset rst_n. While rst_n=0, every stage's data, valid and err bits are 0, so out_data=0, out_valid=0 and sel_err=0. Deassertion takes effect at the next rising clk edge.
- Combinational front end:
  - sel < N: chosen = in_data slice sel.
  - sel >= N: chosen = 0 and err_in = 1.
  - No X-propagation from unused select codes.
- Stage 0 captures {in_valid, chosen, err_in & in_valid}. Stage i captures stage i-1. Outputs are driven by stage STAGES-1.
- Latency: an item presented at edge t appears on the outputs after edge t+STAGES-1, i.e. exactly STAGES clock edges after capture begins.
- Per-edge priority, applied to all stages simultaneously: flush > stall > advance.
  - flush=1: all valid bits, err bits and data become 0, regardless of stall. The input item on that edge is discarded.
  - stall=1, flush=0: every stage holds its contents. The input item is not captured, so the upstream stage must hold it.
  - Otherwise: shift one stage.
- Invalid items (in_valid=0) propagate as bubbles. Their data is still captured (don't-care for consumers) and their err bit is forced to 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). No partial state survives.
- Parameter check: an elaboration-time error when N > 2^SEL_W, N < 2, or STAGES is outside 1..4.
- Output timing: no combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 while driving in_data all-ones, in_valid=1, sel=1 -> out_data=0, out_valid=0, sel_err=0 for every cycle reset is low. Assert rst_n low asynchronously mid-stream -> outputs go to 0 before the next clk edge.
- Select/latency, STAGES=2, N=4: inputs 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444. Drive sel=2, in_valid=1 for one cycle, then in_valid=0 -> out_data=0x33333333 and out_valid=1 exactly 2 edges after capture, for one cycle only.
- Out-of-range, N=3, SEL_W=2: sel=3, in_valid=1 -> out_data=0, out_valid=1, sel_err=1 after STAGES edges. Same select with in_valid=0 -> sel_err stays 0.
- Stall, STAGES=3: stream sel=0,1,2,3 on consecutive cycles, then stall=1 for 3 cycles -> outputs frozen, no item lost or duplicated. After release, the full sequence 0x11..,0x22..,0x33..,0x44.. emerges in order.
- Flush vs stall: pipeline full of valid items, assert flush=1 and stall=1 on the same edge -> all stages clear and out_valid=0 on the next cycle. The item presented on that edge never appears.
- Back-to-back streaming with no stall, STAGES=1: sel changes every cycle 0,1,2,3,0 -> out_data follows one edge later with no bubbles, out_valid continuously 1.

Source files
------------

// File: rtl/mux_pipe_sel.sv
// N-input WIDTH-bit select feeding a STAGES-deep valid-tagged pipeline.
// The pipeline has stall/flush control and reports out-of-range selects.
module mux_pipe_sel #(
  parameter int WIDTH  = 32,
  parameter int N      = 4,
  parameter int SEL_W  = 2,
  parameter int STAGES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               sel_err
);

  generate
    if (N < 2 || N > 16 || N > (1 << SEL_W) || STAGES < 1 || STAGES > 4) begin : g_param_err
      $error("mux_pipe_sel: illegal parameters N=%0d SEL_W=%0d STAGES=%0d", N, SEL_W, STAGES);
    end
  endgenerate

  logic [WIDTH-1:0]  chosen;
  logic              errIn;

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] err_q, err_d;

  // Unused select codes resolve to zero data rather than X.
  always_comb begin
    chosen = '0;
    errIn  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        chosen = in_data[k*WIDTH +: WIDTH];
        errIn  = 1'b0;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (flush) begin
      data_d  = '{default: '0};
      valid_d = '0;
      err_d   = '0;
    end else if (!stall) begin
      data_d[0]  = chosen;
      valid_d[0] = in_valid;
      err_d[0]   = errIn & in_valid;
      for (int i = 1; i < STAGES; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
        err_d[i]   = err_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '{default: '0};
      valid_q <= '0;
      err_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign sel_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Bench for mux_pipe_sel: three configurations driven in lockstep and checked
// against a history-of-accepted-items model.
module tb_mux_pipe_sel;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] inData4;
  logic [95:0]  inData3;
  logic [1:0]   sel;
  logic         inValid, stall, flush;

  logic [31:0]  outData0, outData1, outData2;
  logic         outValid0, outValid1, outValid2;
  logic         selErr0, selErr1, selErr2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         v;
    logic [1:0]   s;
    logic [127:0] d;
  } raw_t;

  // Items accepted since the last flush/reset, oldest first.
  raw_t hist[$];
  logic [31:0] seen[$];

  assign inData4 = {w3, w2, w1, w0};
  assign inData3 = {w2, w1, w0};

  always #5 clk = ~clk;

  mux_pipe_sel #(.WIDTH(32), .N(4), .SEL_W(2), .STAGES(3)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(inData4), .sel(sel), .in_valid(inValid),
    .stall(stall), .flush(flush), .out_data(outData0), .out_valid(outValid0), .sel_err(selErr0));

  mux_pipe_sel #(.WIDTH(32), .N(3), .SEL_W(2), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(inData3), .sel(sel), .in_valid(inValid),
    .stall(stall), .flush(flush), .out_data(outData1), .out_valid(outValid1), .sel_err(selErr1));

  mux_pipe_sel #(.WIDTH(32), .N(4), .SEL_W(2), .STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(inData4), .sel(sel), .in_valid(inValid),
    .stall(stall), .flush(flush), .out_data(outData2), .out_valid(outValid2), .sel_err(selErr2));

  // Returns {valid, err, data} that a pipe of given N and depth should show.
  function automatic logic [33:0] expectOut(int n, int depth);
    raw_t r;
    int   idx;
    if (hist.size() < depth) return '0;
    r   = hist[hist.size() - depth];
    idx = int'(r.s);
    if (idx < n) return {r.v, 1'b0, r.d[idx*32 +: 32]};
    return {r.v, r.v, 32'h0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [33:0] e;
    e = expectOut(4, 3);
    checkOutput("u0.data", outData0, e[31:0]);
    checkOutput("u0.valid", {31'b0, outValid0}, {31'b0, e[33]});
    checkOutput("u0.err", {31'b0, selErr0}, {31'b0, e[32]});
    e = expectOut(3, 1);
    checkOutput("u1.data", outData1, e[31:0]);
    checkOutput("u1.valid", {31'b0, outValid1}, {31'b0, e[33]});
    checkOutput("u1.err", {31'b0, selErr1}, {31'b0, e[32]});
    e = expectOut(4, 2);
    checkOutput("u2.data", outData2, e[31:0]);
    checkOutput("u2.valid", {31'b0, outValid2}, {31'b0, e[33]});
    checkOutput("u2.err", {31'b0, selErr2}, {31'b0, e[32]});
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic st, input logic fl);
    raw_t r;
    inValid = v;
    sel     = s;
    stall   = st;
    flush   = fl;
    @(posedge clk);
    if (!rst_n || fl) begin
      hist.delete();
    end else if (!st) begin
      r.v = v;
      r.s = s;
      r.d = inData4;
      hist.push_back(r);
      if (hist.size() > 4) void'(hist.pop_front());
    end
    #1;
    checkAll();
  endtask

  task automatic setWords(input logic [31:0] a, b, c, d);
    w0 = a; w1 = b; w2 = c; w3 = d;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".d0"}, outData0, 32'h0);
    checkOutput({tag, ".v0"}, {31'b0, outValid0}, 32'h0);
    checkOutput({tag, ".e0"}, {31'b0, selErr0}, 32'h0);
    checkOutput({tag, ".d1"}, outData1, 32'h0);
    checkOutput({tag, ".v1"}, {31'b0, outValid1}, 32'h0);
    checkOutput({tag, ".e1"}, {31'b0, selErr1}, 32'h0);
    checkOutput({tag, ".d2"}, outData2, 32'h0);
    checkOutput({tag, ".v2"}, {31'b0, outValid2}, 32'h0);
    checkOutput({tag, ".e2"}, {31'b0, selErr2}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    inValid = 1'b1;
    sel     = 2'd1;
    stall   = 1'b0;
    flush   = 1'b0;
    setWords('1, '1, '1, '1);

    // Held reset with aggressive inputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
      checkAllZero("rst_hold");
    end
    #2 rst_n = 1'b1;

    // Single item through the STAGES=2 and STAGES=3 pipes.
    setWords(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    checkOutput("lat.u2.v_e1", {31'b0, outValid2}, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("lat.u2.v_e2", {31'b0, outValid2}, 32'h1);
    checkOutput("lat.u2.d_e2", outData2, 32'h33333333);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("lat.u2.v_e3", {31'b0, outValid2}, 32'h0);
    checkOutput("lat.u0.v_e3", {31'b0, outValid0}, 32'h1);
    checkOutput("lat.u0.d_e3", outData0, 32'h33333333);

    // Out-of-range select on the N=3 pipe.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("oor.u1.v", {31'b0, outValid1}, 32'h1);
    checkOutput("oor.u1.e", {31'b0, selErr1}, 32'h1);
    checkOutput("oor.u1.d", outData1, 32'h0);
    applyStimulus(1'b0, 2'd3, 1'b0, 1'b0);
    checkOutput("oor.u1.e_inv", {31'b0, selErr1}, 32'h0);

    // Stream four items, stall three cycles, then drain.
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b0, 1'b0);
      if (outValid0) seen.push_back(outData0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
      checkOutput("stall.frozen", outData0, 32'h22222222);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
      if (outValid0) seen.push_back(outData0);
    end
    checkOutput("stall.count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      checkOutput("stall.order", seen[i], 32'h11111111 * (i + 1));

    // Flush wins over stall; the item on that edge is dropped.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
    checkAllZero("flush");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
      checkOutput("flush.no_ghost", {31'b0, outValid0}, 32'h0);
    end

    // Back-to-back on the single-stage pipe.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 1'b0, 1'b0);
      checkOutput("b2b.u1.v", {31'b0, outValid1}, 32'h1);
      checkOutput("b2b.u1.d", outData1, (i % 4) < 3 ? 32'h11111111 * ((i % 4) + 1) : 32'h0);
    end

    // Randomized traffic with one asynchronous reset mid-stream.
    for (int i = 0; i < 400; i++) begin
      setWords($urandom, $urandom, $urandom, $urandom);
      if (i == 200) begin
        #3 rst_n = 1'b0;
        #1;
        checkAllZero("async_rst");
        hist.delete();
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
      end
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
